// File: rtl/alu8_pkg.sv
// Shared encodings for the serial bitwise logic unit:
// operation codes and controller states.
package alu8_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/logic_bit.sv
// One-bit slice of the logic unit: applies the selected
// bitwise operation to a single operand bit pair.
module logic_bit
    import alu8_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  op_e  op,
    output logic y
);

    always_comb begin
        y = 1'b0;
        unique case (op)
            OP_AND:  y = a_bit & b_bit;
            OP_OR:   y = a_bit | b_bit;
            OP_XOR:  y = a_bit ^ b_bit;
            OP_NOR:  y = ~(a_bit | b_bit);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_logic8.sv
// Bit-serial bitwise logic unit: latches two operands and an op,
// produces one result bit per cycle LSB first, then holds it.
module serial_logic8
    import alu8_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bit_y;

    logic_bit u_bit (
        .a_bit (a_q[0]),
        .b_bit (b_q[0]),
        .op    (op_q),
        .y     (bit_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_e'(op);
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New bit enters at the MSB; after WIDTH shifts
                // the first (LSB) bit has walked down to bit 0.
                res_d = {bit_y, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero      = ~|res_q;

endmodule

// File: tb/tb_serial_logic8.sv
// Randomized self-checking bench for serial_logic8 against a
// word-level reference of the four bitwise operations.
module tb_serial_logic8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_logic8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, wait for result, stall `hold`
    // DONE cycles, then hand it off.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [1:0] top, input int hold,
                          input bit scramble);
        logic [W-1:0] exp;
        int lat;
        exp = ref_op(ta, tb, top);
        chk("idle_rdy", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        op        = top;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a         = W'($urandom);
                b         = W'($urandom);
                op        = 2'($urandom);
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            tick();
            lat++;
        end
        out_ready = 1'b0;
        // DONE reached on the 8th edge after accept: the 9th
        // cycle counting the accepting one.
        chk("latency", lat, 8);
        chk("result", {24'd0, result}, {24'd0, exp});
        chk("zero", {31'd0, zero}, {31'd0, exp == '0});
        chk("rdy_done", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_res", {24'd0, result}, {24'd0, exp});
            chk("hold_zero", {31'd0, zero}, {31'd0, exp == '0});
            chk("hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_vld", {31'd0, out_valid}, 32'd0);
        chk("post_rdy", {31'd0, in_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_res", {24'd0, result}, {24'd0, exp});
    endtask

    logic [W-1:0] q_exp[$];
    logic [W-1:0] e;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_res", {24'd0, result}, 32'd0);

        run_op(8'hA5, 8'h0F, 2'b01, 0, 1'b0);
        run_op(8'hA5, 8'h0F, 2'b00, 0, 1'b0);
        run_op(8'hA5, 8'h0F, 2'b10, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 2'b11, 0, 1'b0);
        run_op(8'h3C, 8'hC3, 2'b00, 5, 1'b0);
        run_op(8'hA5, 8'h0F, 2'b01, 2, 1'b1);
        run_op(8'h5A, 8'h96, 2'b10, 1, 1'b1);

        // Reset during the 4th shift cycle aborts the operation.
        in_valid = 1'b1;
        a        = 8'hA5;
        b        = 8'h0F;
        op       = 2'b01;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_rdy", {31'd0, in_ready}, 32'd1);
        chk("abort_vld", {31'd0, out_valid}, 32'd0);
        chk("abort_res", {24'd0, result}, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_nohs", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 2'b10, 0, 1'b0);

        // Back-to-back: in_valid held high, accepts every 10 cycles.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 2'($urandom);
            chk("b2b_rdy", {31'd0, in_ready}, {31'd0, (n % 10) == 0});
            if ((n % 10) == 0) q_exp.push_back(ref_op(a, b, op));
            tick();
            if ((n % 10) == 8) begin
                e = q_exp.pop_front();
                chk("b2b_vld", {31'd0, out_valid}, 32'd1);
                chk("b2b_res", {24'd0, result}, {24'd0, e});
            end else begin
                chk("b2b_nvld", {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        for (int k = 0; k < 20; k++) begin
            run_op(W'($urandom), W'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_logic8.md
SERIAL_LOGIC8 -- requirements
Module: serial_logic8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand/op request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  bitwise result.
REQ-012 SHALL have port zero  output  1  result equals all zeros.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 A request SHALL be accepted on a cycle with in_valid=1 and in_ready=1, latching a, b and op into internal registers and clearing the bit counter and result register. The FSM SHALL then move to SHIFT.
REQ-017 In SHIFT, the block SHALL compute exactly one result bit per cycle, LSB first, using the latched bit pair and latched op. It SHALL shift that bit into result bit position WIDTH-1 while shifting the result right, and shift the operand registers right by one.
REQ-018 The bit counter SHALL increment once per SHIFT cycle. After the WIDTH-th SHIFT cycle (counter = WIDTH-1), the FSM SHALL go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the accepting edge (9 cycles for WIDTH=8).
REQ-020 In DONE, out_valid SHALL be 1. result and zero SHALL remain stable until a cycle with out_ready=1, after which the FSM SHALL return to IDLE.
REQ-021 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE; input changes during SHIFT SHALL NOT affect the result.
REQ-022 zero SHALL equal the NOR-reduction of result, valid whenever out_valid=1.
REQ-023 Throughput SHALL be at most one request per WIDTH+2 cycles; a request presented in the same cycle that a result is accepted SHALL wait for IDLE.
REQ-024 result SHALL retain its last value after the handshake until the next request is accepted.

Reset
REQ-025 While rst_n=0 at a rising edge: FSM SHALL enter IDLE, and the counter, operand registers and result SHALL be cleared to 0. Outputs SHALL then be in_ready=1, out_valid=0, busy=0, zero=1.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no output handshake. The first cycle after release SHALL be IDLE.

Structure
REQ-027 Op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and FSM state encodings SHALL reside in shared package alu8_pkg.
REQ-028 The per-bit combinational operation SHALL be sub-module logic_bit (inputs a_bit, b_bit, op; output y). It SHALL be instantiated once.

Verification
REQ-029 WIDTH=8, a=8'hA5, b=8'h0F, op=01, out_ready=1: result=8'hAF, zero=0, out_valid high 9 cycles after accept.
REQ-030 Same operands with op=00 -> 8'h05; op=10 -> 8'hAA. a=b=8'hFF with op=11 -> 8'h00 and zero=1.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, result and zero stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-032 Change a, b and op every cycle during SHIFT -> result equals the value computed from the operands latched at accept.
REQ-033 Assert rst_n=0 on the 4th SHIFT cycle for one cycle -> next cycle IDLE, out_valid=0, result=0, zero=1, no result handshake. A following request computes correctly.
REQ-034 Hold in_valid=1 continuously with out_ready=1 -> accepts spaced exactly 10 cycles apart, each result correct.
